sd_clk_generator: RTL and testbench

Produces the SD card clock (sd_clk) from the 50 MHz system clock, using the 16-bit half-period count produced by the upstream clock-divider count generator. Consumes that block's count and its one-cycle-delayed load strobe (clk_div_reset). Provides one-cycle rise/fall strobes for the CMD/DAT shift logic. Also runs the power-up initialisation burst of INIT_CYCLES clocks.

---
 rtl/sd_clk_generator_pkg.sv | 15 +
 rtl/sd_clk_generator_half_period_counter.sv | 13 +
 rtl/sd_clk_generator.sv | 137 +++++++++++++
 tb/tb_sd_clk_generator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_clk_generator_pkg.sv
// Shared constants and state encoding for the SD host clock generator.
package sd_clk_generator_pkg;

  localparam int unsigned SD_CW            = 16;
  localparam int unsigned SD_ICW           = 7;
  localparam int unsigned SD_DEFAULT_COUNT = 125;
  localparam int unsigned SD_INIT_CYCLES   = 80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_INIT = 2'd2
  } sd_clk_state_e;

endpackage

// File: rtl/sd_clk_generator_half_period_counter.sv
// Flags the last clk cycle of an sd_clk half period.
module sd_clk_generator_half_period_counter #(
  parameter int unsigned CW = 16
) (
  input  logic [CW-1:0] cnt,
  input  logic          clear,
  input  logic [CW-1:0] div,
  output logic          boundary_c
);

  assign boundary_c = !clear && (cnt == (div - CW'(1)));

endmodule

// File: rtl/sd_clk_generator.sv
// SD card clock generator: divided sd_clk, rise/fall strobes and the power-up init burst.
module sd_clk_generator
  import sd_clk_generator_pkg::*;
#(
  parameter int unsigned   CW            = SD_CW,
  parameter logic [CW-1:0] DEFAULT_COUNT = CW'(SD_DEFAULT_COUNT),
  parameter int unsigned   INIT_CYCLES   = SD_INIT_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] count,
  input  logic          clk_en,
  input  logic          init_start,
  output logic          sd_clk,
  output logic          sd_rise,
  output logic          sd_fall,
  output logic          running,
  output logic          init_done,
  output logic          err
);

  localparam int unsigned    ICW       = SD_ICW;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES);

  sd_clk_state_e   state;
  sd_clk_state_e   state_next;
  logic [CW-1:0]   div_reg;
  logic [CW-1:0]   act_div;
  logic [CW-1:0]   cnt;
  logic [ICW-1:0]  icnt;

  logic            div_load_c;
  logic [CW-1:0]   div_next_c;
  logic            boundary_c;
  logic            toggle_c;

  logic            sd_clk_d;
  logic            sd_rise_d;
  logic            sd_fall_d;
  logic            running_d;
  logic            init_done_d;
  logic            err_d;
  logic [CW-1:0]   cnt_d;
  logic [ICW-1:0]  icnt_d;
  logic [CW-1:0]   act_div_d;

  assign div_load_c = load && (count != '0);
  assign div_next_c = div_load_c ? count : div_reg;

  sd_clk_generator_half_period_counter #(.CW(CW)) u_half_period (
    .cnt        (cnt),
    .clear      (state == ST_IDLE),
    .div        (act_div),
    .boundary_c (boundary_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; init_start always wins
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (init_start)  state_next = ST_INIT;
        else if (clk_en) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (init_start)                     state_next = ST_INIT;
        else if (!clk_en && !sd_clk)        state_next = ST_IDLE;
        else if (!clk_en && boundary_c)     state_next = ST_IDLE;
      end
      ST_INIT: begin
        if (!init_start && boundary_c && sd_clk && (icnt == INIT_LAST))
          state_next = clk_en ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the clock, strobes and counters
  always_comb begin
    toggle_c    = boundary_c && !((state_next == ST_IDLE) && !sd_clk);
    sd_clk_d    = sd_clk ^ toggle_c;
    sd_rise_d   = toggle_c && !sd_clk;
    sd_fall_d   = toggle_c && sd_clk;
    running_d   = (state_next != ST_IDLE);
    err_d       = load && (count == '0);
    cnt_d       = cnt + CW'(1);
    icnt_d      = icnt;
    init_done_d = init_done;
    act_div_d   = act_div;

    if ((state_next == ST_IDLE) || (state == ST_IDLE) || boundary_c) cnt_d = '0;

    // New divisor only takes effect at a phase boundary, never mid-phase
    if (boundary_c || (state == ST_IDLE)) act_div_d = div_next_c;

    if (init_start)                                  icnt_d = '0;
    else if ((state == ST_INIT) && sd_rise_d)        icnt_d = icnt + ICW'(1);

    if (init_start)                                  init_done_d = 1'b0;
    else if ((state == ST_INIT) && (icnt == INIT_LAST)) init_done_d = 1'b1;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg   <= DEFAULT_COUNT;
      act_div   <= DEFAULT_COUNT;
      cnt       <= '0;
      icnt      <= '0;
      sd_clk    <= 1'b0;
      sd_rise   <= 1'b0;
      sd_fall   <= 1'b0;
      running   <= 1'b0;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (div_load_c) div_reg <= count;
      act_div   <= act_div_d;
      cnt       <= cnt_d;
      icnt      <= icnt_d;
      sd_clk    <= sd_clk_d;
      sd_rise   <= sd_rise_d;
      sd_fall   <= sd_fall_d;
      running   <= running_d;
      init_done <= init_done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_sd_clk_generator.sv
// Bench for sd_clk_generator: directed scenarios plus random traffic against a phase-countdown model.
module tb_sd_clk_generator;

  localparam int DEF    = 125;
  localparam int INIT_N = 80;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] count = 16'd0;
  logic        clk_en = 1'b0;
  logic        init_start = 1'b0;
  logic        sd_clk, sd_rise, sd_fall, running, init_done, err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: mode 0 idle, 1 run, 2 init; m_left = cycles left in the current phase
  int m_mode, m_left, m_div, m_rises;
  bit m_clk, m_rise, m_fall, m_done, m_err;

  always #10 clk = ~clk;

  sd_clk_generator dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .count      (count),
    .clk_en     (clk_en),
    .init_start (init_start),
    .sd_clk     (sd_clk),
    .sd_rise    (sd_rise),
    .sd_fall    (sd_fall),
    .running    (running),
    .init_done  (init_done),
    .err        (err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int nd);
    m_left--;
    if (m_left <= 0) begin
      if (m_clk) m_fall = 1'b1;
      else       m_rise = 1'b1;
      m_clk  = !m_clk;
      m_left = nd;
    end
  endtask

  task automatic model_edge();
    int nd;
    if (reset) begin
      m_mode = 0; m_clk = 0; m_rise = 0; m_fall = 0; m_done = 0; m_err = 0;
      m_div = DEF; m_rises = 0; m_left = 0;
      return;
    end
    m_err = load && (count == 16'd0);
    nd = (load && count != 16'd0) ? int'(count) : m_div;
    if (init_start)                            m_done = 1'b0;
    else if (m_mode == 2 && m_rises == INIT_N) m_done = 1'b1;
    m_rise = 0;
    m_fall = 0;
    case (m_mode)
      0: if (init_start || clk_en) begin
           m_mode = init_start ? 2 : 1;
           m_left = nd;
           if (init_start) m_rises = 0;
         end
      1: if (init_start) begin
           m_mode = 2; m_rises = 0; tick(nd);
         end else if (!clk_en && !m_clk) begin
           m_mode = 0;
         end else begin
           tick(nd);
           if (m_fall && !clk_en) m_mode = 0;
         end
      default: begin
        tick(nd);
        if (init_start)                          m_rises = 0;
        else if (m_rise)                         m_rises++;
        else if (m_fall && m_rises == INIT_N)    m_mode = clk_en ? 1 : 0;
      end
    endcase
    m_div = nd;
  endtask

  // One clock: advance the model on the edge, then compare all outputs
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk(tag, int'({sd_clk, sd_rise, sd_fall, running, init_done, err}),
        int'({m_clk, m_rise, m_fall, m_mode != 0, m_done, m_err}));
  endtask

  task automatic wait_rise(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step(tag);
      n++;
    end while (!sd_rise && n < budget);
  endtask

  initial begin
    int n, rises, last_rise, bad_iv, extra, done_cyc, highs;

    // Reset and idle
    step("reset");
    step("reset");
    chk("reset_outputs", int'({sd_clk, sd_rise, sd_fall, running, init_done, err}), 0);
    reset = 1'b0;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      step("idle");
      rises += int'(sd_rise) + int'(sd_fall);
    end
    chk("idle_no_strobes", rises, 0);

    // Divisor 2, free running
    load = 1'b1; count = 16'd2;
    step("load2");
    load = 1'b0;
    clk_en = 1'b1;
    step("enter_run");
    wait_rise("run2", 10, n);
    chk("first_rise_latency", n, 2);
    highs = 0; rises = 0;
    for (int i = 0; i < 12; i++) begin
      step("run2");
      highs += int'(sd_clk);
      rises += int'(sd_rise);
    end
    chk("high_cycles_per_3_periods", highs, 6);
    chk("rises_in_12_cycles", rises, 3);

    // clk_en drop while high: phase completes, then stays low
    wait_rise("drop_hi", 10, n);
    clk_en = 1'b0;
    step("drop_hi");
    chk("still_high", int'(sd_clk), 1);
    step("drop_hi");
    chk("single_fall", int'(sd_fall), 1);
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      step("held_low");
      rises += int'(sd_rise);
    end
    chk("no_rise_after_stop", rises, 0);
    chk("stopped_running", int'(running), 0);

    // clk_en drop while low: idle on the next cycle
    clk_en = 1'b1;
    n = 0;
    do begin step("drop_lo"); n++; end while (!sd_fall && n < 20);
    clk_en = 1'b0;
    step("drop_lo");
    chk("idle_after_low_drop", int'(running), 0);

    // Mid-run load 5 one cycle after a rise
    clk_en = 1'b1;
    wait_rise("midload", 20, n);
    step("midload");
    load = 1'b1; count = 16'd5;
    step("midload");
    load = 1'b0;
    chk("old_high_phase_2", int'(sd_fall), 1);
    wait_rise("midload", 20, n);
    chk("new_low_phase_5", n, 5);

    // Zero count rejected
    load = 1'b1; count = 16'd0;
    step("err");
    load = 1'b0;
    chk("err_pulse", int'(err), 1);
    step("err");
    chk("err_one_cycle", int'(err), 0);
    wait_rise("err_period", 20, n);
    wait_rise("err_period", 20, n);
    chk("period_unchanged", n, 10);

    // Init burst at the default divisor
    clk_en = 1'b0;
    reset = 1'b1;
    step("reset2");
    reset = 1'b0;
    init_start = 1'b1;
    step("init");
    init_start = 1'b0;
    rises = 0; last_rise = 0; bad_iv = 0; done_cyc = 0;
    for (int i = 0; i < 21000 && !init_done; i++) begin
      step("init");
      if (sd_rise) begin
        if (rises > 0 && (cyc - last_rise) != 2 * DEF) bad_iv++;
        rises++;
        last_rise = cyc;
      end
      if (init_done) done_cyc = cyc;
    end
    chk("init_done_seen", int'(init_done), 1);
    chk("init_rise_count", rises, INIT_N);
    chk("init_rise_spacing", bad_iv, 0);
    chk("init_done_lag", done_cyc - last_rise, 1);
    extra = 0;
    for (int i = 0; i < 400 && running; i++) begin
      step("init_tail");
      extra += int'(sd_rise);
    end
    chk("init_no_extra_rise", extra, 0);
    chk("init_stops_low", int'({sd_clk, running}), 0);

    // Reset in the middle of a burst
    load = 1'b1; count = 16'd3;
    step("init2");
    load = 1'b0;
    init_start = 1'b1;
    step("init2");
    init_start = 1'b0;
    chk("done_cleared", int'(init_done), 0);
    for (int i = 0; i < 30; i++) step("init2");
    reset = 1'b1;
    step("reset_mid_init");
    chk("reset_mid_init", int'({sd_clk, sd_rise, sd_fall, running, init_done, err}), 0);
    reset = 1'b0;

    // Random traffic with small divisors
    for (int i = 0; i < 5000; i++) begin
      load       = ($urandom_range(0, 19) == 0);
      count      = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 59) == 0) clk_en = !clk_en;
      init_start = ($urandom_range(0, 399) == 0);
      reset      = ($urandom_range(0, 1999) == 0);
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
